// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch
// Operand-fetch initiator for a 32x32 register file with a one-cycle
// registered read. It accepts a two-source request, drives the RF read
// addresses and waits out the read latency. It returns both operands over a
// valid/ready handshake. The RF write port is passed straight through.
// Writes that race with or follow the RF read are forwarded into the pending
// and held operands, so a returned value is never stale.
//
// Optional feature macro: RF_ZERO_REG_EN
//   When defined, register 0 reads as zero. Writes to register 0 are
//   suppressed at the RF port and are never forwarded.
//   When undefined, register 0 behaves like any other register.

module rf_operand_fetch #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   // operand request
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rs,
   input  logic [ADDR_W-1:0] req_rt,
   // writeback traffic (never back-pressured)
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   // register file ports
   output logic [ADDR_W-1:0] rf_reg1,
   output logic [ADDR_W-1:0] rf_reg2,
   output logic [ADDR_W-1:0] rf_writereg,
   output logic              rf_write,
   output logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] rf_read1,
   input  logic [DATA_W-1:0] rf_read2,
   // operand response
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_a,
   output logic [DATA_W-1:0] rsp_b
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t r_state;
   logic   r_req_ready;
   logic   r_rsp_valid;

   // Qualified write: what actually reaches the RF this cycle
   logic   w_wb_eff;

   genvar gi;

`ifdef RF_ZERO_REG_EN
   assign w_wb_eff = wb_valid & rst_n & (wb_reg != '0);
`else
   assign w_wb_eff = wb_valid & rst_n;
`endif

   // Write port is a pure pass-through; only the strobe is qualified
   assign rf_write    = w_wb_eff;
   assign rf_writereg = wb_reg;
   assign rf_data     = wb_data;

   // Request/response sequencing; handshake outputs are registered with the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_state     <= ST_READ;
                  r_req_ready <= 1'b0;
               end
            end
            ST_READ: begin
               // RF samples the addresses at the end of this cycle
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // RF data is presented now and captured at the end of this cycle
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
            end
            ST_RESP: begin
               // Return to IDLE only; a new request waits one more cycle
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;

   // One identical lane per source operand: lane 0 is rs/A, lane 1 is rt/B
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [ADDR_W-1:0] w_req_idx;
         logic [DATA_W-1:0] w_rf_read;
         logic              w_zero_idx;
         logic              w_wb_hit;
         logic [DATA_W-1:0] w_capture;

         logic [ADDR_W-1:0] r_idx;
         logic              r_ovr_valid;
         logic [DATA_W-1:0] r_ovr_data;
         logic [DATA_W-1:0] r_rsp;

         assign w_req_idx = (gi == 0) ? req_rs   : req_rt;
         assign w_rf_read = (gi == 0) ? rf_read1 : rf_read2;

`ifdef RF_ZERO_REG_EN
         assign w_zero_idx = (r_idx == '0);
`else
         assign w_zero_idx = 1'b0;
`endif

         // A write to this lane's register index in the current cycle
         assign w_wb_hit = w_wb_eff & (wb_reg == r_idx) & ~w_zero_idx;

         // Capture priority: hardwired zero, then a write landing in WAIT,
         // then the latest override from READ, then the RF read data
         always_comb begin
            w_capture = w_rf_read;
            if (w_zero_idx) begin
               w_capture = '0;
            end else if (w_wb_hit) begin
               w_capture = wb_data;
            end else if (r_ovr_valid) begin
               w_capture = r_ovr_data;
            end
         end

         // Per-operand address, pending override and held response value
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_idx       <= '0;
               r_ovr_valid <= 1'b0;
               r_ovr_data  <= '0;
               r_rsp       <= '0;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (req_valid) begin
                        r_idx       <= w_req_idx;
                        r_ovr_valid <= 1'b0;
                     end
                  end
                  ST_READ: begin
                     // The RF read at this edge returns pre-write data, so keep the write
                     if (w_wb_hit) begin
                        r_ovr_valid <= 1'b1;
                        r_ovr_data  <= wb_data;
                     end
                  end
                  ST_WAIT: begin
                     r_rsp <= w_capture;
                  end
                  ST_RESP: begin
                     // Keep the held operand tracking the architectural value
                     if (w_wb_hit) begin
                        r_rsp <= wb_data;
                     end
                  end
                  default: begin
                     r_ovr_valid <= 1'b0;
                  end
               endcase
            end
         end
      end
   endgenerate

   assign rf_reg1 = g_lane[0].r_idx;
   assign rf_reg2 = g_lane[1].r_idx;
   assign rsp_a   = g_lane[0].r_rsp;
   assign rsp_b   = g_lane[1].r_rsp;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Testbench for rf_operand_fetch: contains a registered-read register file
// model, an architectural register array used as the reference, and a
// directed-then-randomised sequence of requests and writebacks.
// The expectations follow RF_ZERO_REG_EN when that macro is defined.

module tb_rf_operand_fetch;

   localparam int DW = 32;
   localparam int AW = 5;

`ifdef RF_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_rs;
   logic [AW-1:0] req_rt;
   logic          wb_valid;
   logic [AW-1:0] wb_reg;
   logic [DW-1:0] wb_data;
   logic [AW-1:0] rf_reg1;
   logic [AW-1:0] rf_reg2;
   logic [AW-1:0] rf_writereg;
   logic          rf_write;
   logic [DW-1:0] rf_data;
   logic [DW-1:0] rf_read1;
   logic [DW-1:0] rf_read2;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_a;
   logic [DW-1:0] rsp_b;

   int compared   = 0;
   int mismatched = 0;

   // Architectural register values: every accepted write lands here at its edge
   logic [DW-1:0] arch [32];

   // Register file model: synchronous write, registered read of pre-write data
   logic [DW-1:0] rf_mem [32];
   logic          rf_clear;

   rf_operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rs      (req_rs),
      .req_rt      (req_rt),
      .wb_valid    (wb_valid),
      .wb_reg      (wb_reg),
      .wb_data     (wb_data),
      .rf_reg1     (rf_reg1),
      .rf_reg2     (rf_reg2),
      .rf_writereg (rf_writereg),
      .rf_write    (rf_write),
      .rf_data     (rf_data),
      .rf_read1    (rf_read1),
      .rf_read2    (rf_read2),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_a       (rsp_a),
      .rsp_b       (rsp_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      end else if (rf_write) begin
         rf_mem[rf_writereg] <= rf_data;
      end
      rf_read1 <= rf_mem[rf_reg1];
      rf_read2 <= rf_mem[rf_reg2];
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] expv(input logic [AW-1:0] r);
      if (ZERO_EN && r == '0) return '0;
      return arch[r];
   endfunction

   // One clock: architectural update at the rising edge, then back to the falling edge
   task automatic cycle();
      @(posedge clk);
      if (rst_n && wb_valid && !(ZERO_EN && wb_reg == '0)) arch[wb_reg] = wb_data;
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   // Writeback stimulus for one phase: optional random traffic biased to rs/rt,
   // with a directed write taking precedence in its chosen phase
   task automatic drive_wb(input int ph, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input bit rnd, input int dph, input logic [AW-1:0] dreg,
                           input logic [DW-1:0] dd);
      if (rnd && $urandom_range(0, 99) < 50) begin
         wb_valid = 1'b1;
         case ($urandom_range(0, 2))
            0:       wb_reg = rs;
            1:       wb_reg = rt;
            default: wb_reg = AW'($urandom_range(0, 31));
         endcase
         wb_data = $urandom;
      end
      if (dph == ph) begin
         wb_valid = 1'b1;
         wb_reg   = dreg;
         wb_data  = dd;
      end
   endtask

   // Full request transaction. Phases: 0 accept, 1 READ, 2 WAIT, 3.. RESP cycles
   task automatic request(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input int hold,
                          input bit rnd, input int dph, input logic [AW-1:0] dreg,
                          input logic [DW-1:0] dd);
      chk("req_ready_idle", {31'b0, req_ready}, 1);
      req_valid = 1'b1;
      req_rs    = rs;
      req_rt    = rt;
      drive_wb(0, rs, rt, rnd, dph, dreg, dd);
      cycle();
      req_valid = 1'b0;
      req_rs    = AW'($urandom);
      req_rt    = AW'($urandom);
      chk("req_ready_read", {31'b0, req_ready}, 0);
      chk("rsp_valid_read", {31'b0, rsp_valid}, 0);
      chk("rf_reg1", {27'b0, rf_reg1}, {27'b0, rs});
      chk("rf_reg2", {27'b0, rf_reg2}, {27'b0, rt});
      drive_wb(1, rs, rt, rnd, dph, dreg, dd);
      cycle();
      chk("rsp_valid_wait", {31'b0, rsp_valid}, 0);
      chk("req_ready_wait", {31'b0, req_ready}, 0);
      drive_wb(2, rs, rt, rnd, dph, dreg, dd);
      cycle();
      chk("rsp_valid_resp", {31'b0, rsp_valid}, 1);
      chk("rsp_a", rsp_a, expv(rs));
      chk("rsp_b", rsp_b, expv(rt));
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         drive_wb(3 + h, rs, rt, rnd, dph, dreg, dd);
         cycle();
         chk("rsp_valid_hold", {31'b0, rsp_valid}, 1);
         chk("rsp_a_hold", rsp_a, expv(rs));
         chk("rsp_b_hold", rsp_b, expv(rt));
      end
      $display("req rs=%0d rt=%0d hold=%0d a=%h b=%h", rs, rt, hold, rsp_a, rsp_b);
      rsp_ready = 1'b1;
      drive_wb(3 + hold, rs, rt, rnd, dph, dreg, dd);
      cycle();
      rsp_ready = 1'b0;
      chk("rsp_valid_done", {31'b0, rsp_valid}, 0);
   endtask

   task automatic write_reg(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wb_valid = 1'b1;
      wb_reg   = r;
      wb_data  = d;
      cycle();
   endtask

   // Time limit in case the sequence ever stalls
   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) arch[i] = '0;
      rst_n     = 1'b0;
      rf_clear  = 1'b1;
      req_valid = 1'b0;
      req_rs    = '0;
      req_rt    = '0;
      rsp_ready = 1'b0;
      wb_valid  = 1'b1;
      wb_reg    = 5'd3;
      wb_data   = 32'hCAFE_0003;

      // Reset state, with a write presented while reset is held
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_a", rsp_a, 0);
      chk("rst_rsp_b", rsp_b, 0);
      chk("rst_rf_reg1", {27'b0, rf_reg1}, 0);
      chk("rst_rf_reg2", {27'b0, rf_reg2}, 0);
      chk("rst_rf_write", {31'b0, rf_write}, 0);
      rf_clear = 1'b0;
      wb_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 1);
      $display("reset released");

      // Write pass-through
      wb_valid = 1'b1;
      wb_reg   = 5'd5;
      wb_data  = 32'hDEAD_BEEF;
      #1;
      chk("rf_write_pass", {31'b0, rf_write}, 1);
      chk("rf_writereg_pass", {27'b0, rf_writereg}, 32'd5);
      chk("rf_data_pass", rf_data, 32'hDEAD_BEEF);
      cycle();
      write_reg(5'd6, 32'h0000_0012);
      cycle();
      request(5'd5, 5'd6, 0, 1'b0, -1, '0, '0);

      // Write to rs in the READ cycle must be forwarded
      write_reg(5'd7, 32'h0000_0001);
      request(5'd7, 5'd8, 0, 1'b0, 1, 5'd7, 32'hA5A5_A5A5);
      // Write to rt in the WAIT cycle must be forwarded
      request(5'd10, 5'd11, 0, 1'b0, 2, 5'd11, 32'h1357_9BDF);
      // Held response updates after a write to rs==rt
      request(5'd9, 5'd9, 2, 1'b0, 3, 5'd9, 32'h0000_0055);

      // Register 0 behaviour
      wb_valid = 1'b1;
      wb_reg   = 5'd0;
      wb_data  = 32'hFFFF_FFFF;
      #1;
      chk("rf_write_r0", {31'b0, rf_write}, ZERO_EN ? 32'd0 : 32'd1);
      cycle();
      request(5'd0, 5'd5, 0, 1'b0, -1, '0, '0);
      request(5'd0, 5'd0, 1, 1'b0, 1, 5'd0, 32'h0BAD_0000);

      // Randomised back-to-back traffic over a small register window
      for (int n = 0; n < 40; n++) begin
         request(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 $urandom_range(0, 2), 1'b1, -1, '0, '0);
      end

      // Reset during WAIT aborts the request
      req_valid = 1'b1;
      req_rs    = 5'd5;
      req_rt    = 5'd6;
      cycle();
      req_valid = 1'b0;
      cycle();
      rst_n    = 1'b0;
      wb_valid = 1'b1;
      wb_reg   = 5'd4;
      wb_data  = 32'h4444_4444;
      #1;
      chk("midrst_rf_write", {31'b0, rf_write}, 0);
      cycle();
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("midrst_rsp_a", rsp_a, 0);
      chk("midrst_rf_reg1", {27'b0, rf_reg1}, 0);
      rst_n = 1'b1;
      #1;
      chk("midrst_req_ready", {31'b0, req_ready}, 1);
      cycle();
      chk("midrst_no_rsp", {31'b0, rsp_valid}, 0);
      $display("reset during WAIT done");

      // Normal operation resumes after the abort
      request(5'd4, 5'd5, 0, 1'b1, -1, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
